gpi_periph: RTL
===============

Name: gpi_periph

Overview:
- Memory-mapped general-purpose input peripheral. It is the read-side counterpart of the GPO output peripheral on the data bus.
- Synchronises and debounces 8 external input pins and latches edge events in sticky flags.
- Raises a level interrupt for enabled events.
- Shares the CPU data-memory address/data bus. It decodes its own word addresses, and its read data is OR-muxed with DataMemory output by the top level.

Parameters:
- WIDTH, 8, number of input pins (register fields are WIDTH bits, zero-extended to 32).
- DEBOUNCE, 16, consecutive cycles a synchronised level must differ from the stable level before being accepted. Legal range 1..2^CNT_W-1.
- CNT_W, 16, width of each per-pin debounce counter.
- BASE, 10'h54, byte address of the STATE register. EDGE is at BASE+4, MASK at BASE+8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- address  input  10  byte address from the data bus. Decode uses address[9:2] only.
- read  input  1  bus read strobe
- write  input  1  bus write strobe
- data_in  input  8  write data (low byte of bus store data)
- pins  input  WIDTH  asynchronous external inputs
- data_out  output  32  registered read data
- irq  output  1  interrupt request, level

Behaviour:
- Reset (rst high at posedge):
  - sync stages, stable, debounce counters, EDGE and MASK are all cleared to 0.
  - data_out is set to 32'b0.
  - irq is 0 from the following cycle.
  - Reset mid-debounce discards the partial count.
- Synchroniser:
  - Two flops per pin: q1 <= pins, q2 <= q1.
  - No logic reads q1.
- Debounce, per bit i, at each edge:
  - If q2[i] != stable[i] and cnt[i] == DEBOUNCE-1: stable[i] <= q2[i] and cnt[i] <= 0.
  - Else if q2[i] != stable[i]: cnt[i] <= cnt[i]+1.
  - Else: cnt[i] <= 0. Any glitch back to the stable level restarts the count.
  - Latency: if pins change before edge k and then hold, stable updates at edge k+1+DEBOUNCE.
- Edge flags:
  - EDGE[i] is set on the edge where stable[i] changes, in either direction.
  - Write to BASE+4 is write-1-to-clear: EDGE <= (EDGE & ~data_in) | set.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- MASK:
  - Write to BASE+8 loads MASK <= data_in[WIDTH-1:0].
  - Writes to STATE (BASE) are ignored.
- irq:
  - Combinational OR of the registers: irq = |(EDGE & MASK).
  - Rises the cycle after the EDGE set edge, provided the bit is masked in.
- Read:
  - One-cycle latency. At a posedge with read high and address[9:2] matching a register, data_out <= {zero-extend, reg}.
  - Otherwise data_out <= 32'b0, so the value can be OR-muxed.
  - A read samples the register value before any same-edge update. Example: reading EDGE at the edge where a flag sets returns the old value.
  - Reads have no side effects.
- Address decode:
  - Unmapped addresses, and write with read both low, cause no state change.
  - Simultaneous read and write to the same register: the read returns the pre-write value and the write takes effect.

Test Plan:
- Reset value: hold rst 2 cycles with pins=8'hFF, release, read BASE immediately -> data_out=32'h0. With pins held, a read issued after edge k+1+DEBOUNCE=17 cycles returns 32'h000000FF.
- Glitch rejection: stable=0. Drive pins[3]=1 for 10 cycles then 0 (DEBOUNCE=16) -> STATE stays 0, EDGE stays 0, irq stays 0.
- Edge + irq:
  - Write MASK=8'h04 at BASE+8, then hold pins[2]=1.
  - At stable change -> EDGE reads 32'h04, and irq=1 the cycle after the set.
  - Write 8'h04 to BASE+4 -> EDGE=0, irq=0 next cycle.
- Masked event: MASK=0, toggle pins[5] and hold -> EDGE=32'h20, irq stays 0. Then write MASK=8'h20 -> irq=1 the cycle after.
- Set/clear collision: time a W1C of bit 1 to the exact edge where stable[1] changes -> EDGE[1] remains 1.
- Reset mid-debounce and decode: assert rst when cnt[0]=10 -> after release, the pin needs a full 16 (+1 sync) cycles to register. Reads at 10'h60 and writes at 10'h50 -> data_out=0 and no register change.

Source files
------------

// File: rtl/gpi_periph.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : gpi_periph                                                 |
// | Brief   : Memory-mapped general-purpose input peripheral. Two-flop   |
// |           synchroniser, per-pin debounce, sticky W1C edge flags,     |
// |           interrupt mask and OR-muxable registered read data.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module gpi_periph #(
  parameter int          WIDTH    = 8,
  parameter int          DEBOUNCE = 16,
  parameter int          CNT_W    = 16,
  parameter logic [9:0]  BASE     = 10'h54
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [7:0]       data_in,
  input  logic [WIDTH-1:0] pins,
  output logic [31:0]      data_out,
  output logic             irq
);

  localparam logic [9:0]       C_EDGE_ADDR = BASE + 10'd4;
  localparam logic [9:0]       C_MASK_ADDR = BASE + 10'd8;
  localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      data_out_q, data_out_d;

  logic             sel_state, sel_edge, sel_mask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] edge_set;

  // Byte-lane bits are not part of the word decode.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];

  // Per-pin debounce: the synchronised level must disagree with the stable
  // level for DEBOUNCE consecutive cycles; any agreement restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_bit_d;

    // Next count and next stable level for this pin.
    always_comb begin
      cnt_d        = '0;
      stable_bit_d = stable_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q == C_CNT_LAST) begin
          stable_bit_d = sync2_q[i];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    // Counter register; reset discards any partial count.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign stable_d[i] = stable_bit_d;
  end

  // Register decode, W1C edge flags with set priority, mask load, read mux.
  always_comb begin
    sel_state  = (address[9:2] == BASE[9:2]);
    sel_edge   = (address[9:2] == C_EDGE_ADDR[9:2]);
    sel_mask   = (address[9:2] == C_MASK_ADDR[9:2]);
    wdata      = WIDTH'(data_in);
    edge_set   = stable_d ^ stable_q;

    edge_d     = edge_q | edge_set;
    mask_d     = mask_q;
    data_out_d = 32'b0;

    if (write && sel_edge) begin
      edge_d = (edge_q & ~wdata) | edge_set;
    end
    if (write && sel_mask) begin
      mask_d = wdata;
    end

    // Reads see the current register values, before this edge's update.
    if (read) begin
      if (sel_state) begin
        data_out_d = 32'(stable_q);
      end else if (sel_edge) begin
        data_out_d = 32'(edge_q);
      end else if (sel_mask) begin
        data_out_d = 32'(mask_q);
      end
    end
  end

  // Synchroniser, stable levels, flags, mask and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      edge_q     <= '0;
      mask_q     <= '0;
      data_out_q <= 32'b0;
    end else begin
      sync1_q    <= pins;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      data_out_q <= data_out_d;
    end
  end

  assign data_out = data_out_q;
  assign irq      = |(edge_q & mask_q);

endmodule
`default_nettype wire
